// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, one full-adder slice, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_step;
  logic             sum_bit;
  logic             carry_nxt;

  // Full-adder slice on the current LSBs of the shifting operand registers.
  assign sum_bit   = op_a[0] ^ op_b[0] ^ carry;
  assign carry_nxt = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (state == ADD) && (cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status decode; start is only honoured outside ADD.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = ADD;
      ADD: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? ADD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and one bit per cycle; subtract is a + ~b + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      res   <= '0;
      carry <= sub ? 1'b1 : c_in;
      cnt   <= '0;
    end else if (state == ADD) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= {sum_bit, res[WIDTH-1:1]};
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
    end
  end

  // Visible results update only on the final slice; carry here is the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (last_step) begin
      sum      <= {sum_bit, res[WIDTH-1:1]};
      c_out    <= carry_nxt;
      overflow <= carry ^ carry_nxt;
    end
  end

endmodule
